// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Brief    : Frame constants, status codes and FSM state type for the
//            UART command engine.
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_REQ = 8'hA5;
    localparam logic [7:0] SYNC_RSP = 8'h5A;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;

    localparam logic [7:0] ST_OK    = 8'h00;
    localparam logic [7:0] ST_CHK   = 8'h01;
    localparam logic [7:0] ST_CMD   = 8'h02;
    localparam logic [7:0] ST_ADDR  = 8'h03;

    typedef enum logic [3:0] {
        HUNT        = 4'd0,
        GET_CMD     = 4'd1,
        GET_ADDR    = 4'd2,
        GET_DATA    = 4'd3,
        GET_CHK     = 4'd4,
        EXEC        = 4'd5,
        SEND_SYNC   = 4'd6,
        SEND_STATUS = 4'd7,
        SEND_DATA   = 4'd8,
        SEND_CHK    = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte_fetch.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_byte_fetch
// Brief    : Pops bytes from the RX FIFO, holding off RX_ACCEPT_GAP cycles
//            after each pop to cover the FIFO RAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte_fetch #(
    parameter int RX_ACCEPT_GAP = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_accept,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int c_GW = (RX_ACCEPT_GAP < 1) ? 1 : $clog2(RX_ACCEPT_GAP + 1);

    logic [c_GW-1:0] r_gap;
    logic            r_valid;
    logic [7:0]      r_byte;
    logic            w_take;

    assign w_take = enable && rx_data_ready && (r_gap == '0) && !reset;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_gap   <= '0;
            r_valid <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_valid <= w_take;
            if (w_take) begin
                r_byte <= rx_data;
                r_gap  <= c_GW'(RX_ACCEPT_GAP);
            end else if (r_gap != '0) begin
                r_gap <= r_gap - c_GW'(1);
            end
        end
    end

    assign rx_accept  = w_take;
    assign byte_valid = r_valid;
    assign byte_data  = r_byte;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_engine
// Brief    : Parses 5-byte request frames from the RX FIFO, executes register
//            reads/writes and returns 4-byte response frames to the TX FIFO.
//            Optional inter-byte timeout enabled by UART_CMD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_engine #(
    parameter int         NUM_REGS       = 8,
    parameter logic [7:0] VERSION_ID     = 8'h11,
    parameter int         RX_ACCEPT_GAP  = 2,
    parameter int         TIMEOUT_CYCLES = 1440000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    output logic       rx_accept,
    output logic [7:0] tx_data,
    output logic       tx_wren,
    input  logic       tx_fifo_full,
    input  logic [7:0] status_in,
    output logic [7:0] led_out,
    output logic [7:0] ctrl_out,
    output logic [7:0] frame_err_cnt
);

    import uart_cmd_pkg::*;

    localparam int         c_AW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] c_NUM_REGS     = 8'(NUM_REGS);
    localparam logic [7:0] c_ADDR_STATUS  = 8'd2;
    localparam logic [7:0] c_ADDR_VERSION = 8'(NUM_REGS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cmd, r_addr, r_data, r_chk;
    logic [7:0] r_status, r_rsp_data, r_err_cnt;
    logic [7:0] r_regs [NUM_REGS];
    logic       r_tx_hold;

    logic       w_in_frame, w_rx_enable, w_byte_valid, w_timeout;
    logic [7:0] w_byte, w_status, w_read_val, w_tx_data;
    logic       w_tx_wren;

    assign w_in_frame  = (r_state == GET_CMD) || (r_state == GET_ADDR) ||
                         (r_state == GET_DATA) || (r_state == GET_CHK);
    assign w_rx_enable = (r_state == HUNT) || w_in_frame;

    uart_rx_byte_fetch #(
        .RX_ACCEPT_GAP (RX_ACCEPT_GAP)
    ) u_fetch (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .enable        (w_rx_enable),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_accept     (rx_accept),
        .byte_valid    (w_byte_valid),
        .byte_data     (w_byte)
    );

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] r_timeout_cnt;

    always_ff @(posedge sys_clk) begin
        if (reset || !w_in_frame || w_byte_valid) begin
            r_timeout_cnt <= '0;
        end else if (r_timeout_cnt != 32'(TIMEOUT_CYCLES)) begin
            r_timeout_cnt <= r_timeout_cnt + 32'd1;
        end
    end

    assign w_timeout = w_in_frame && !w_byte_valid &&
                       (r_timeout_cnt == 32'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    // Checks are ordered: checksum, then command, then address legality.
    always_comb begin
        w_status = ST_OK;
        if (r_chk != (r_cmd ^ r_addr ^ r_data)) begin
            w_status = ST_CHK;
        end else if ((r_cmd != CMD_WR) && (r_cmd != CMD_RD)) begin
            w_status = ST_CMD;
        end else if ((r_addr >= c_NUM_REGS) ||
                     ((r_cmd == CMD_WR) &&
                      ((r_addr == c_ADDR_STATUS) || (r_addr == c_ADDR_VERSION)))) begin
            w_status = ST_ADDR;
        end
    end

    always_comb begin
        w_read_val = r_regs[r_addr[c_AW-1:0]];
        if (r_addr == c_ADDR_STATUS) begin
            w_read_val = status_in;
        end else if (r_addr == c_ADDR_VERSION) begin
            w_read_val = VERSION_ID;
        end
    end

    // r_tx_hold forces an idle cycle after every push so the FIFO's
    // registered full flag is current before the next one.
    always_comb begin
        w_next    = r_state;
        w_tx_wren = 1'b0;
        w_tx_data = 8'h00;
        case (r_state)
            HUNT:     if (w_byte_valid && (w_byte == SYNC_REQ)) w_next = GET_CMD;
            GET_CMD:  if (w_byte_valid) w_next = GET_ADDR;
            GET_ADDR: if (w_byte_valid) w_next = GET_DATA;
            GET_DATA: if (w_byte_valid) w_next = GET_CHK;
            GET_CHK:  if (w_byte_valid) w_next = EXEC;
            EXEC:     w_next = SEND_SYNC;
            SEND_SYNC: begin
                w_tx_data = SYNC_RSP;
                if (!tx_fifo_full && !r_tx_hold) begin
                    w_tx_wren = 1'b1;
                    w_next    = SEND_STATUS;
                end
            end
            SEND_STATUS: begin
                w_tx_data = r_status;
                if (!tx_fifo_full && !r_tx_hold) begin
                    w_tx_wren = 1'b1;
                    w_next    = SEND_DATA;
                end
            end
            SEND_DATA: begin
                w_tx_data = r_rsp_data;
                if (!tx_fifo_full && !r_tx_hold) begin
                    w_tx_wren = 1'b1;
                    w_next    = SEND_CHK;
                end
            end
            SEND_CHK: begin
                w_tx_data = r_status ^ r_rsp_data;
                if (!tx_fifo_full && !r_tx_hold) begin
                    w_tx_wren = 1'b1;
                    w_next    = HUNT;
                end
            end
            default:  w_next = HUNT;
        endcase
        if (w_timeout) begin
            w_next = HUNT;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= HUNT;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_chk      <= '0;
            r_status   <= '0;
            r_rsp_data <= '0;
            r_err_cnt  <= '0;
            r_tx_hold  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state   <= w_next;
            r_tx_hold <= w_tx_wren;
            if (w_byte_valid) begin
                case (r_state)
                    GET_CMD:  r_cmd  <= w_byte;
                    GET_ADDR: r_addr <= w_byte;
                    GET_DATA: r_data <= w_byte;
                    GET_CHK:  r_chk  <= w_byte;
                    default:  ;
                endcase
            end
            if (r_state == EXEC) begin
                r_status <= w_status;
                if (w_status != ST_OK) begin
                    r_rsp_data <= 8'h00;
                end else if (r_cmd == CMD_WR) begin
                    r_rsp_data                <= r_data;
                    r_regs[r_addr[c_AW-1:0]] <= r_data;
                end else begin
                    r_rsp_data <= w_read_val;
                end
            end
            if ((((r_state == EXEC) && (w_status != ST_OK)) || w_timeout) &&
                (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign tx_wren       = w_tx_wren;
    assign tx_data       = w_tx_data;
    assign led_out       = r_regs[0];
    assign ctrl_out      = r_regs[1];
    assign frame_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_engine
// Brief    : Self-checking bench for uart_cmd_engine: directed frame table,
//            randomized frames against a reference model, multi-cycle cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_engine;

    localparam int         NUM_REGS   = 8;
    localparam logic [7:0] VERSION_ID = 8'h11;
    localparam int         GAP        = 2;

    logic       sys_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_ready = 1'b0;
    logic       rx_accept;
    logic [7:0] tx_data;
    logic       tx_wren;
    logic       tx_fifo_full = 1'b0;
    logic [7:0] status_in = 8'h00;
    logic [7:0] led_out, ctrl_out, frame_err_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_q [$];
    logic [7:0] tx_q [$];
    int         acc_cnt = 0;
    int         wren_cnt = 0;
    int         cyc = 0;
    int         last_acc = -100;
    logic       prev_wren = 1'b0;

    logic [7:0] m_regs [NUM_REGS];
    int         m_err = 0;

    typedef struct {
        logic [39:0] frame;
        logic [7:0]  st_in;
        logic [7:0]  exp_st;
        logic [7:0]  exp_dat;
        logic [7:0]  exp_led;
        logic [7:0]  exp_ctrl;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [10];

    always #5 sys_clk = ~sys_clk;

    uart_cmd_engine #(
        .NUM_REGS       (NUM_REGS),
        .VERSION_ID     (VERSION_ID),
        .RX_ACCEPT_GAP  (GAP),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .sys_clk       (sys_clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .rx_accept     (rx_accept),
        .tx_data       (tx_data),
        .tx_wren       (tx_wren),
        .tx_fifo_full  (tx_fifo_full),
        .status_in     (status_in),
        .led_out       (led_out),
        .ctrl_out      (ctrl_out),
        .frame_err_cnt (frame_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: pop happens on the edge that ends the rx_accept cycle.
    initial begin
        logic acc;
        forever begin
            @(negedge sys_clk);
            acc = rx_accept;
            @(posedge sys_clk);
            #1;
            if (acc && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_data_ready = (rx_q.size() != 0);
            rx_data       = rx_data_ready ? rx_q[0] : 8'h00;
        end
    end

    // Bus monitor: pop spacing, push legality, TX byte capture.
    always @(negedge sys_clk) begin
        cyc++;
        if (rx_accept) begin
            acc_cnt++;
            chk("rx_gap_ok", 32'((cyc - last_acc) > GAP), 32'd1);
            last_acc = cyc;
        end
        if (tx_wren) begin
            chk("tx_wren_full_or_back_to_back", {30'd0, tx_fifo_full, prev_wren}, 32'd0);
            tx_q.push_back(tx_data);
            wren_cnt++;
        end
        prev_wren = tx_wren;
    end

    function automatic vec_t mk(input logic [39:0] f, input logic [7:0] si, input logic [7:0] st,
                                input logic [7:0] d, input logic [7:0] led, input logic [7:0] ctl,
                                input logic [7:0] er);
        vec_t v;
        v.frame = f; v.st_in = si; v.exp_st = st; v.exp_dat = d;
        v.exp_led = led; v.exp_ctrl = ctl; v.exp_err = er;
        return v;
    endfunction

    // Reference model working directly from the request rules.
    function automatic void model(input logic [39:0] f, input logic [7:0] si,
                                  output logic [7:0] st, output logic [7:0] dat);
        logic [7:0] cmd, addr, data, ck;
        int         a;
        bit         writable;
        cmd = f[31:24]; addr = f[23:16]; data = f[15:8]; ck = f[7:0];
        a = int'(addr);
        writable = (a < NUM_REGS) && (a != 2) && (a != NUM_REGS - 1);
        dat = 8'h00;
        if ((cmd ^ addr ^ data) != ck)                     st = 8'h01;
        else if (cmd != 8'h57 && cmd != 8'h52)             st = 8'h02;
        else if (a >= NUM_REGS || (cmd == 8'h57 && !writable)) st = 8'h03;
        else                                               st = 8'h00;
        if (st == 8'h00) begin
            if (cmd == 8'h57) begin
                m_regs[a] = data;
                dat = data;
            end else if (a == 2) dat = si;
            else if (a == NUM_REGS - 1) dat = VERSION_ID;
            else dat = m_regs[a];
        end else if (m_err < 255) begin
            m_err++;
        end
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic push_frame(input logic [39:0] f);
        for (int i = 0; i < 5; i++) rx_q.push_back(f[39-8*i -: 8]);
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] st, input logic [7:0] dat);
        int n;
        n = 0;
        while (tx_q.size() < 4 && n < 400) begin
            step();
            n++;
        end
        if (tx_q.size() < 4) begin
            chk({tag, "_rsp_timeout"}, 32'(tx_q.size()), 32'd4);
            tx_q.delete();
        end else begin
            chk({tag, "_sync"},   32'(tx_q.pop_front()), 32'h5A);
            chk({tag, "_status"}, 32'(tx_q.pop_front()), 32'(st));
            chk({tag, "_data"},   32'(tx_q.pop_front()), 32'(dat));
            chk({tag, "_chk"},    32'(tx_q.pop_front()), 32'(st ^ dat));
        end
        step();
    endtask

    function automatic logic [39:0] build(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        return {8'hA5, c, a, d, c ^ a ^ d};
    endfunction

    initial begin
        logic [7:0]  st, dat, c, a, d, k;
        logic [39:0] f;
        int          a0, w0, n;

        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  st, dat, c, a, d, k;
        logic [39:0] f;
        int          a0, w0, n;

        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;

        vecs[0] = mk(40'hA5_57_00_3C_6B, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'd0);
        vecs[1] = mk(40'hA5_52_02_00_50, 8'h9E, 8'h00, 8'h9E, 8'h3C, 8'h00, 8'd0);
        vecs[2] = mk(40'hA5_57_01_FF_00, 8'h00, 8'h01, 8'h00, 8'h3C, 8'h00, 8'd1);
        vecs[3] = mk(40'hA5_52_08_00_5A, 8'h00, 8'h03, 8'h00, 8'h3C, 8'h00, 8'd2);
        vecs[4] = mk(40'hA5_57_07_55_05, 8'h00, 8'h03, 8'h00, 8'h3C, 8'h00, 8'd3);
        vecs[5] = mk(40'hA5_52_07_00_55, 8'h00, 8'h00, 8'h11, 8'h3C, 8'h00, 8'd3);
        vecs[6] = mk(40'hA5_41_00_00_41, 8'h00, 8'h02, 8'h00, 8'h3C, 8'h00, 8'd4);
        vecs[7] = mk(40'hA5_57_01_C3_95, 8'h00, 8'h00, 8'hC3, 8'h3C, 8'hC3, 8'd4);
        vecs[8] = mk(40'hA5_52_00_00_52, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'hC3, 8'd4);
        vecs[9] = mk(40'hA5_57_02_11_44, 8'h00, 8'h03, 8'h00, 8'h3C, 8'hC3, 8'd5);

        // Reset state
        repeat (3) step();
        chk("reset_rx_accept", 32'(rx_accept), 32'd0);
        chk("reset_tx_wren",   32'(tx_wren),   32'd0);
        chk("reset_tx_data",   32'(tx_data),   32'd0);
        chk("reset_led",       32'(led_out),   32'd0);
        chk("reset_ctrl",      32'(ctrl_out),  32'd0);
        chk("reset_err",       32'(frame_err_cnt), 32'd0);
        reset = 1'b0;
        step();

        // Directed frame table
        for (int i = 0; i < 10; i++) begin
            status_in = vecs[i].st_in;
            a0 = acc_cnt;
            push_frame(vecs[i].frame);
            expect_rsp($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_dat);
            chk($sformatf("vec%0d_accepts", i), 32'(acc_cnt - a0), 32'd5);
            chk($sformatf("vec%0d_led", i),  32'(led_out),  32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_out), 32'(vecs[i].exp_ctrl));
            chk($sformatf("vec%0d_err", i),  32'(frame_err_cnt), 32'(vecs[i].exp_err));
            model(vecs[i].frame, vecs[i].st_in, st, dat);
        end

        // Back-pressure: hold full across SEND_STATUS
        f = build(8'h57, 8'h01, 8'h5A);
        push_frame(f);
        model(f, status_in, st, dat);
        n = 0;
        while (tx_q.size() < 1 && n < 200) begin
            step();
            n++;
        end
        chk("bp_sync_seen", 32'(tx_q.size() >= 1), 32'd1);
        tx_fifo_full = 1'b1;
        w0 = wren_cnt;
        a0 = acc_cnt;
        push_frame(build(8'h52, 8'h01, 8'h00));
        repeat (20) step();
        chk("bp_no_wren_while_full", 32'(wren_cnt - w0), 32'd0);
        chk("bp_no_accept_while_full", 32'(acc_cnt - a0), 32'd0);
        tx_fifo_full = 1'b0;
        expect_rsp("bp_rsp", st, dat);
        model(build(8'h52, 8'h01, 8'h00), status_in, st, dat);
        expect_rsp("bp_next", st, dat);
        chk("bp_ctrl", 32'(ctrl_out), 32'h5A);

        // Randomized frames against the model
        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(0, 3));
            c = (n < 2) ? 8'h57 : (n == 2) ? 8'h52 : 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 9));
            d = 8'($urandom_range(0, 255));
            k = c ^ a ^ d;
            if ($urandom_range(0, 7) == 0) k = k ^ (8'h01 << $urandom_range(0, 7));
            status_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rx_q.push_back(8'($urandom_range(0, 2) * 8'h3C));
            f = {8'hA5, c, a, d, k};
            push_frame(f);
            model(f, status_in, st, dat);
            expect_rsp($sformatf("rnd%0d", i), st, dat);
            chk($sformatf("rnd%0d_led", i),  32'(led_out),  32'(m_regs[0]));
            chk($sformatf("rnd%0d_ctrl", i), 32'(ctrl_out), 32'(m_regs[1]));
            chk($sformatf("rnd%0d_err", i),  32'(frame_err_cnt), 32'(m_err));
        end

        // Garbage then reset mid-frame
        f = build(8'h57, 8'h00, 8'h77);
        push_frame(f);
        model(f, status_in, st, dat);
        expect_rsp("pre_reset_wr", st, dat);
        chk("pre_reset_led", 32'(led_out), 32'h77);
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
        rx_q.push_back(8'hA5); rx_q.push_back(8'h57);
        repeat (20) step();
        reset = 1'b1;
        repeat (2) step();
        rx_q.delete();
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_err = 0;
        step();
        chk("post_reset_led",  32'(led_out),  32'd0);
        chk("post_reset_ctrl", 32'(ctrl_out), 32'd0);
        chk("post_reset_err",  32'(frame_err_cnt), 32'd0);
        chk("post_reset_no_tx", 32'(tx_q.size()), 32'd0);
        push_frame(40'hA5_52_00_00_52);
        expect_rsp("post_reset_rd", 8'h00, 8'h00);

`ifdef UART_CMD_TIMEOUT_EN
        // Partial frame abandoned after the inter-byte timeout
        rx_q.push_back(8'hA5); rx_q.push_back(8'h57);
        repeat (150) step();
        chk("timeout_no_tx", 32'(tx_q.size()), 32'd0);
        chk("timeout_err",   32'(frame_err_cnt), 32'(m_err + 1));
        m_err++;
        push_frame(40'hA5_57_00_3C_6B);
        expect_rsp("timeout_recover", 8'h00, 8'h3C);
        chk("timeout_led", 32'(led_out), 32'h3C);
`endif

        repeat (5) step();
        chk("final_tx_idle", 32'(tx_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
